// File: rtl/multisim_arb_pkg.sv
// Shared constants, types and width helper for the multisim client arbiter
// and any later schedulers built on the same rotate-priority picker.
package multisim_arb_pkg;

   localparam int MAX_N_REQ  = 16;
   localparam int ARB_DATA_W = 64;

   typedef logic [ARB_DATA_W-1:0] arb_data_t;

   // Index width for n items; never narrower than one bit so ports stay legal.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multisim_rr_pick.sv
// Combinational rotate-priority picker: the first requester after `last_i`
// (wrapping, `last_i` itself checked last) wins.
module multisim_rr_pick
   import multisim_arb_pkg::*;
#(
   parameter int  N  = 4,
   localparam int IW = idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   always_comb begin
      int j;
      j     = 0;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      // Walk from the farthest offset to the nearest so the nearest hit is written last.
      for (int k = N; k >= 1; k--) begin
         j = (int'(last_i) + k) % N;
         if (req_i[IW'(j)]) begin
            gnt_o        = '0;
            gnt_o[IW'(j)] = 1'b1;
            idx_o        = IW'(j);
            any_o        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multisim_client_arbiter.sv
// Shares one multisim_client data channel between N_REQ producers: round-robin
// with optional burst lock and a registered output stage.
// Optional source tag output enabled by defining MULTISIM_ARB_SRC_TAG_EN.
module multisim_client_arbiter
   import multisim_arb_pkg::*;
#(
   parameter int  N_REQ     = 4,
   parameter int  DATA_W    = 64,
   parameter int  MAX_BURST = 1,
   localparam int IDX_W     = idx_w(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        in_vld,
   output logic [N_REQ-1:0]        in_rdy,
   input  logic [N_REQ*DATA_W-1:0] in_data,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [DATA_W-1:0]       out_data,
   output logic [IDX_W-1:0]        out_src,
   output logic                    busy
);

   localparam int BURST_W = idx_w(MAX_BURST);

   logic                out_vld_q, out_vld_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [BURST_W-1:0]  burst_q, burst_d;

   logic                load_en;
   logic                hold_burst;
   logic                take;
   logic [IDX_W-1:0]    sel;
   logic [DATA_W-1:0]   sel_data;
   logic [N_REQ-1:0]    rr_gnt;
   logic [IDX_W-1:0]    rr_idx;
   logic                rr_any;

   multisim_rr_pick #(
      .N (N_REQ)
   ) u_pick (
      .req_i  (in_vld),
      .last_i (last_q),
      .gnt_o  (rr_gnt),
      .idx_o  (rr_idx),
      .any_o  (rr_any)
   );

   // Slot is free or draining this cycle; in_rdy is held low while reset is asserted.
   assign load_en    = !out_vld_q || out_rdy;
   assign hold_burst = (int'(burst_q) < MAX_BURST - 1) && in_vld[last_q];
   assign sel        = hold_burst ? last_q : rr_idx;
   assign take       = rst_n && load_en && rr_any;
   assign sel_data   = in_data[int'(sel)*DATA_W +: DATA_W];

   always_comb begin
      in_rdy = '0;
      if (take) begin
         in_rdy = hold_burst ? '0 : rr_gnt;
         in_rdy[sel] = 1'b1;
      end
   end

   always_comb begin
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      last_d     = last_q;
      burst_d    = burst_q;
      if (load_en) begin
         out_vld_d = take;
         if (take) begin
            out_data_d = sel_data;
            last_d     = sel;
            // A repeat grant (burst or lone requester) counts up and saturates.
            if (sel == last_q) begin
               if (int'(burst_q) < MAX_BURST - 1) begin
                  burst_d = burst_q + BURST_W'(1);
               end
            end else begin
               burst_d = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         last_q     <= IDX_W'(N_REQ - 1);
         burst_q    <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         out_data_q <= out_data_d;
         last_q     <= last_d;
         burst_q    <= burst_d;
      end
   end

`ifdef MULTISIM_ARB_SRC_TAG_EN
   logic [IDX_W-1:0] src_q, src_d;

   always_comb begin
      src_d = src_q;
      if (take) begin
         src_d = sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_q <= '0;
      end else begin
         src_q <= src_d;
      end
   end

   assign out_src = src_q;
`else
   assign out_src = '0;
`endif

   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;
   assign busy     = out_vld_q || (|in_vld);

endmodule

// File: tb/tb_multisim_client_arbiter.sv
// Bench for multisim_client_arbiter: a pure round-robin instance and a
// MAX_BURST=3 instance, both checked against a grant-rule reference model.
module tb_multisim_client_arbiter;

   localparam int N  = 4;
   localparam int W  = 64;
   localparam int IW = 2;

   logic clk;
   logic rst_n;

   logic [N-1:0]   in_vld_t   [2];
   logic [N-1:0]   in_rdy_t   [2];
   logic [N*W-1:0] in_data_t  [2];
   logic           out_vld_t  [2];
   logic           out_rdy_t  [2];
   logic [W-1:0]   out_data_t [2];
   logic [IW-1:0]  out_src_t  [2];
   logic           busy_t     [2];

   int total = 0;
   int bad   = 0;

   // Reference model: last winner, length of its current run, output slot.
   int           m_last [2];
   int           m_run  [2];
   int           m_src  [2];
   logic         m_vld  [2];
   logic [W-1:0] m_data [2];
   int           glog0 [$];
   int           glog1 [$];

   multisim_client_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(1)) dut_rr (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (in_vld_t[0]),
      .in_rdy   (in_rdy_t[0]),
      .in_data  (in_data_t[0]),
      .out_vld  (out_vld_t[0]),
      .out_rdy  (out_rdy_t[0]),
      .out_data (out_data_t[0]),
      .out_src  (out_src_t[0]),
      .busy     (busy_t[0])
   );

   multisim_client_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(3)) dut_burst (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_vld   (in_vld_t[1]),
      .in_rdy   (in_rdy_t[1]),
      .in_data  (in_data_t[1]),
      .out_vld  (out_vld_t[1]),
      .out_rdy  (out_rdy_t[1]),
      .out_data (out_data_t[1]),
      .out_src  (out_src_t[1]),
      .busy     (busy_t[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int max_burst(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   // Winner under the grant rules, or -1 when nobody is valid.
   function automatic int pick(input int u);
      logic [N-1:0] v;
      v = in_vld_t[u];
      if (m_run[u] < max_burst(u) && v[m_last[u]]) return m_last[u];
      for (int k = 1; k <= N; k++) begin
         if (v[(m_last[u] + k) % N]) return (m_last[u] + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_rdy(input int u);
      logic [N-1:0] r;
      int s;
      r = '0;
      s = pick(u);
      if (rst_n && (!m_vld[u] || out_rdy_t[u]) && s >= 0) r[s] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_vld[u]  = 1'b0;
         m_data[u] = '0;
         m_src[u]  = 0;
         m_last[u] = N - 1;
         m_run[u]  = 1;
      end
   endtask

   task automatic model_update();
      int s;
      for (int u = 0; u < 2; u++) begin
         if (!m_vld[u] || out_rdy_t[u]) begin
            s = pick(u);
            if (s >= 0) begin
               m_data[u] = in_data_t[u][s*W +: W];
               if (s == m_last[u]) m_run[u] = (m_run[u] < max_burst(u)) ? m_run[u] + 1 : m_run[u];
               else m_run[u] = 1;
               m_last[u] = s;
               m_src[u]  = s;
               m_vld[u]  = 1'b1;
               if (u == 0) glog0.push_back(s);
               else glog1.push_back(s);
            end else begin
               m_vld[u] = 1'b0;
            end
         end
      end
   endtask

   task automatic check_all();
      logic [63:0] esrc;
      for (int u = 0; u < 2; u++) begin
`ifdef MULTISIM_ARB_SRC_TAG_EN
         esrc = 64'(m_src[u]);
`else
         esrc = 64'd0;
`endif
         check($sformatf("u%0d_in_rdy", u), 64'(in_rdy_t[u]), 64'(exp_rdy(u)));
         check($sformatf("u%0d_out_vld", u), 64'(out_vld_t[u]), 64'(m_vld[u]));
         check($sformatf("u%0d_out_data", u), out_data_t[u], m_data[u]);
         check($sformatf("u%0d_out_src", u), 64'(out_src_t[u]), esrc);
         check($sformatf("u%0d_busy", u), 64'(busy_t[u]), 64'(m_vld[u] || (|in_vld_t[u])));
      end
   endtask

   task automatic step(input logic [N-1:0] v0, input logic [N-1:0] v1, input logic r0, input logic r1);
      @(negedge clk);
      in_vld_t[0]  = v0;
      in_vld_t[1]  = v1;
      out_rdy_t[0] = r0;
      out_rdy_t[1] = r1;
      for (int u = 0; u < 2; u++) begin
         for (int i = 0; i < N; i++) in_data_t[u][i*W +: W] = {$urandom(), $urandom()};
      end
      #1 check_all();
      @(posedge clk);
      model_update();
   endtask

   // Asynchronous reset pulse right after an active edge, inputs still valid.
   task automatic rst_mid();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all();
      in_vld_t[0] = '0;
      in_vld_t[1] = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_log(input string tag, input int u, input int exp[]);
      int got;
      for (int i = 0; i < exp.size(); i++) begin
         if (u == 0) got = (i < glog0.size()) ? glog0[i] : -1;
         else got = (i < glog1.size()) ? glog1[i] : -1;
         check($sformatf("%s_%0d", tag, i), 64'(got), 64'(exp[i]));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         in_vld_t[u]  = 4'hF;
         out_rdy_t[u] = 1'b1;
         in_data_t[u] = '0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all();
      in_vld_t[0] = '0;
      in_vld_t[1] = '0;
      rst_n = 1'b1;

      glog0.delete(); glog1.delete();
      repeat (8) step(4'hF, 4'hF, 1'b1, 1'b1);
      check_log("fair", 0, '{0, 1, 2, 3, 0, 1, 2, 3});

      repeat (5) step(4'hF, 4'hF, 1'b0, 1'b0);
      repeat (2) step(4'hF, 4'hF, 1'b1, 1'b1);

      rst_mid();
      glog0.delete(); glog1.delete();
      repeat (9) step(4'b0110, 4'b0110, 1'b1, 1'b1);
      check_log("burst", 1, '{1, 1, 1, 2, 2, 2, 1, 1, 1});
      check_log("rr_pair", 0, '{1, 2, 1, 2});

      glog0.delete(); glog1.delete();
      repeat (3) step(4'b1000, 4'b1000, 1'b1, 1'b1);
      repeat (4) step(4'b0001, 4'b0001, 1'b1, 1'b1);
      check_log("wrap0", 0, '{3, 3, 3, 0, 0, 0, 0});
      check_log("wrap1", 1, '{3, 3, 3, 0, 0, 0, 0});

      for (int c = 0; c < 600; c++) begin
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      end

      repeat (3) step(4'hF, 4'hF, 1'b0, 1'b0);
      rst_mid();
      glog0.delete(); glog1.delete();
      repeat (4) step(4'hF, 4'hF, 1'b1, 1'b1);
      check_log("restart", 0, '{0, 1, 2, 3});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
